// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong game-state controller.
package pong_pkg;

    typedef enum logic [1:0] {
        NEWGAME = 2'd0,
        PLAY    = 2'd1,
        NEWBALL = 2'd2,
        OVER    = 2'd3
    } state_t;

    localparam int BALLS_DEF       = 3;
    localparam int TIMER_TICKS_DEF = 120;
    localparam int DIG_W           = 4;

endpackage

// File: rtl/pong_bcd_score.sv
// Two-digit BCD score counter; 99 wraps to 00, clear beats increment.
module pong_bcd_score
    import pong_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [DIG_W-1:0] dig1,
    output logic [DIG_W-1:0] dig0
);

    logic [DIG_W-1:0] dig1_q, dig1_d;
    logic [DIG_W-1:0] dig0_q, dig0_d;

    always_comb begin
        dig1_d = dig1_q;
        dig0_d = dig0_q;
        if (clr) begin
            dig1_d = '0;
            dig0_d = '0;
        end else if (inc) begin
            if (dig0_q == 4'd9) begin
                dig0_d = '0;
                dig1_d = (dig1_q == 4'd9) ? 4'd0 : dig1_q + 4'd1;
            end else begin
                dig0_d = dig0_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dig1_q <= '0;
            dig0_q <= '0;
        end else begin
            dig1_q <= dig1_d;
            dig0_q <= dig0_d;
        end
    end

    assign dig1 = dig1_q;
    assign dig0 = dig0_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Round FSM, spare-ball count and inter-round pause timer for Pong.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int BALLS       = BALLS_DEF,
    parameter int TIMER_TICKS = TIMER_TICKS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             refr_tick,
    input  logic [1:0]       btn,
    input  logic             hit,
    input  logic             miss,
    output logic [DIG_W-1:0] dig1,
    output logic [DIG_W-1:0] dig0,
    output logic [1:0]       ball,
    output logic             gra_still,
    output logic             show_rule,
    output logic             show_over
);

    localparam logic [1:0] BALLS_INIT = 2'(BALLS);
    localparam logic [6:0] TICKS_INIT = 7'(TIMER_TICKS);

    state_t     state_q, state_d;
    logic [1:0] ball_q, ball_d;
    logic [6:0] timer_q, timer_d;
    logic       still_q, still_d;
    logic       rule_q, rule_d;
    logic       over_q, over_d;
    logic       score_clr, score_inc;
    logic       pressed;

    assign pressed = (btn != 2'b00);

    always_comb begin
        state_d   = state_q;
        ball_d    = ball_q;
        timer_d   = timer_q;
        score_clr = 1'b0;
        score_inc = 1'b0;
        if (refr_tick && timer_q != 7'd0)
            timer_d = timer_q - 7'd1;
        case (state_q)
            NEWGAME: begin
                score_clr = 1'b1;
                if (pressed) begin
                    state_d = PLAY;
                    ball_d  = ball_q - 2'd1;
                end
            end
            PLAY: begin
                // a miss overrides a coincident hit
                if (miss) begin
                    timer_d = TICKS_INIT;
                    if (ball_q == 2'd0) begin
                        state_d = OVER;
                    end else begin
                        state_d = NEWBALL;
                        ball_d  = ball_q - 2'd1;
                    end
                end else if (hit) begin
                    score_inc = 1'b1;
                end
            end
            NEWBALL: begin
                if (timer_q == 7'd0 && pressed)
                    state_d = PLAY;
            end
            OVER: begin
                if (timer_q == 7'd0) begin
                    state_d   = NEWGAME;
                    ball_d    = BALLS_INIT;
                    score_clr = 1'b1;
                end
            end
            default: state_d = NEWGAME;
        endcase
        still_d = (state_d != PLAY);
        rule_d  = (state_d == NEWGAME);
        over_d  = (state_d == OVER);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= NEWGAME;
            ball_q  <= BALLS_INIT;
            timer_q <= '0;
            still_q <= 1'b1;
            rule_q  <= 1'b1;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ball_q  <= ball_d;
            timer_q <= timer_d;
            still_q <= still_d;
            rule_q  <= rule_d;
            over_q  <= over_d;
        end
    end

    pong_bcd_score u_score (
        .clk   (clk),
        .reset (reset),
        .clr   (score_clr),
        .inc   (score_inc),
        .dig1  (dig1),
        .dig0  (dig0)
    );

    assign ball      = ball_q;
    assign gra_still = still_q;
    assign show_rule = rule_q;
    assign show_over = over_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with hand-computed expectations.
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       refr_tick = 1'b0;
    logic [1:0] btn = 2'b00;
    logic       hit = 1'b0;
    logic       miss = 1'b0;
    logic [3:0] dig1, dig0;
    logic [1:0] ball;
    logic       gra_still, show_rule, show_over;

    int total = 0;
    int bad = 0;

    pong_game_ctrl #(.BALLS(3), .TIMER_TICKS(120)) dut (
        .clk       (clk),
        .reset     (reset),
        .refr_tick (refr_tick),
        .btn       (btn),
        .hit       (hit),
        .miss      (miss),
        .dig1      (dig1),
        .dig0      (dig0),
        .ball      (ball),
        .gra_still (gra_still),
        .show_rule (show_rule),
        .show_over (show_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // drive inputs, let one rising edge pass, sample 1 time unit later
    task automatic cyc(input logic [1:0] b, input logic h, input logic m,
                       input logic r);
        btn = b;
        hit = h;
        miss = m;
        refr_tick = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [7:0] score,
                           input logic [1:0] balls, input logic [2:0] flags);
        check({tag, ".score"}, {dig1, dig0}, score);
        check({tag, ".ball"}, ball, balls);
        check({tag, ".flags"}, {gra_still, show_rule, show_over}, flags);
    endtask

    initial begin
        // flags = {gra_still, show_rule, show_over}
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 8'h00, 2'd3, 3'b110);
        reset = 1'b0;
        cyc(2'b00, 1'b0, 1'b0, 1'b0);

        cyc(2'b00, 1'b1, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b1, 1'b1);
        chk_all("ng_ignore", 8'h00, 2'd3, 3'b110);

        cyc(2'b01, 1'b0, 1'b0, 1'b0);
        chk_all("start", 8'h00, 2'd2, 3'b000);
        cyc(2'b00, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) cyc(2'b00, 1'b1, 1'b0, 1'b0);
        chk_all("hit10", 8'h10, 2'd2, 3'b000);
        cyc(2'b11, 1'b0, 1'b0, 1'b0);
        chk_all("play_btn", 8'h10, 2'd2, 3'b000);

        for (int i = 0; i < 89; i++) cyc(2'b00, 1'b1, 1'b0, 1'b0);
        check("hit99", {dig1, dig0}, 8'h99);
        cyc(2'b00, 1'b1, 1'b0, 1'b0);
        check("wrap00", {dig1, dig0}, 8'h00);
        for (int i = 0; i < 3; i++) cyc(2'b00, 1'b1, 1'b0, 1'b0);
        check("hit03", {dig1, dig0}, 8'h03);

        cyc(2'b00, 1'b1, 1'b1, 1'b0);
        chk_all("hitmiss", 8'h03, 2'd1, 3'b100);
        cyc(2'b00, 1'b1, 1'b0, 1'b0);
        chk_all("nb_hit", 8'h03, 2'd1, 3'b100);

        for (int i = 0; i < 119; i++) cyc(2'b10, 1'b0, 1'b0, 1'b1);
        chk_all("nb_119", 8'h03, 2'd1, 3'b100);
        cyc(2'b10, 1'b0, 1'b0, 1'b1);
        check("nb_t0_edge", {gra_still, show_rule, show_over}, 3'b100);
        cyc(2'b10, 1'b0, 1'b0, 1'b0);
        chk_all("nb_exit", 8'h03, 2'd1, 3'b000);

        // tick coincident with the miss must not shorten the pause
        cyc(2'b00, 1'b0, 1'b1, 1'b1);
        chk_all("miss2", 8'h03, 2'd0, 3'b100);
        for (int i = 0; i < 119; i++) cyc(2'b01, 1'b0, 1'b0, 1'b1);
        check("nb2_119", {gra_still, show_rule, show_over}, 3'b100);
        cyc(2'b01, 1'b0, 1'b0, 1'b1);
        check("nb2_t0", {gra_still, show_rule, show_over}, 3'b100);
        cyc(2'b01, 1'b0, 1'b0, 1'b0);
        check("nb2_exit", {gra_still, show_rule, show_over}, 3'b000);

        cyc(2'b00, 1'b1, 1'b0, 1'b0);
        cyc(2'b00, 1'b1, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b1, 1'b0);
        chk_all("over", 8'h05, 2'd0, 3'b101);

        cyc(2'b11, 1'b0, 1'b0, 1'b0);
        cyc(2'b00, 1'b1, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b1, 1'b0);
        chk_all("over_ign", 8'h05, 2'd0, 3'b101);

        for (int i = 0; i < 119; i++) cyc(2'b00, 1'b0, 1'b0, 1'b1);
        chk_all("over_119", 8'h05, 2'd0, 3'b101);
        cyc(2'b00, 1'b0, 1'b0, 1'b1);
        chk_all("over_t0", 8'h05, 2'd0, 3'b101);
        cyc(2'b00, 1'b0, 1'b0, 1'b0);
        chk_all("regame", 8'h00, 2'd3, 3'b110);

        cyc(2'b10, 1'b0, 1'b0, 1'b0);
        cyc(2'b00, 1'b1, 1'b0, 1'b0);
        cyc(2'b00, 1'b1, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b1, 1'b0);
        chk_all("g2_nb", 8'h02, 2'd1, 3'b100);
        cyc(2'b00, 1'b0, 1'b0, 1'b0);

        #2;
        reset = 1'b1;
        #1;
        chk_all("async_rst", 8'h00, 2'd3, 3'b110);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        cyc(2'b01, 1'b0, 1'b0, 1'b0);
        chk_all("post_rst", 8'h00, 2'd2, 3'b000);
        cyc(2'b00, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
